pipeline_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage ARM64 pipeline (IF, ID, EX, MEM, WB).
- Watches ID source registers, the EX load destination, EX branch resolution and the data-memory busy line.
- Drives the write-enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC source select.
- Holds a small state machine with a memory-wait timeout that traps on a hung memory.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants for the 5-stage pipeline: FSM encodings, register-index
// width, the zero-register index and the NOP loaded by flushed registers.
package pipeline_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_XZR = 5'd31;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_TRAP = 2'd2;

  // ARM64 NOP instruction word that a flushed IF/ID or ID/EX register carries.
  localparam logic [31:0] NOP_INSN = 32'hD503_201F;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector: an EX-stage load whose destination feeds a source
// register read by the ID-stage instruction. The zero register never conflicts.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter logic [REG_W-1:0] ZR_IDX = REG_XZR
) (
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             luh
);

  logic rn_hit;
  logic rm_hit;

  always_comb begin
    rn_hit = id_use_rn && (id_rn == ex_rd);
    rm_hit = id_use_rm && (id_rm == ex_rd);
    luh    = ex_memread && (ex_rd != ZR_IDX) && (rn_hit || rm_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the IF/ID/EX/MEM/WB pipeline with a memory-wait
// timeout trap. Optional performance counters are enabled by HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned      MEM_TIMEOUT = 16,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [REG_W-1:0] ZR_IDX      = REG_XZR
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             trap,
  output logic [1:0]       state_o,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam bit               TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  logic             luh;
  logic             decide;

  hazard_detect #(.ZR_IDX(ZR_IDX)) u_hazard_detect (
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_use_rn  (id_use_rn),
    .id_use_rm  (id_use_rm),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .luh        (luh)
  );

  always_comb begin
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_write   = 1'b0;
    idex_flush   = 1'b0;
    exmem_write  = 1'b0;
    memwb_write  = 1'b0;
    trap         = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    decide       = 1'b0;
    wait_cnt_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

    case (state_q)
      ST_RUN: decide = 1'b1;
      ST_WAIT: begin
        if (mem_busy) begin
          wait_cnt_d = wait_cnt_inc;
          // Count includes the busy cycle that entered WAIT from RUN.
          if (TIMEOUT_EN && (wait_cnt_inc >= TIMEOUT_CNT)) begin
            state_d = ST_TRAP;
          end
        end else begin
          decide     = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_TRAP: trap = 1'b1;
      default: state_d = ST_RUN;
    endcase

    if (decide) begin
      if (mem_busy) begin
        state_d    = ST_WAIT;
        wait_cnt_d = CNT_W'(1);
      end else if (ex_branch_taken) begin
        pc_sel      = 1'b1;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_write  = 1'b1;
        idex_flush  = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
      end else if (luh) begin
        idex_write  = 1'b1;
        idex_flush  = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
      end
    end

    // The pipeline must stay quiet for as long as reset is held.
    if (!resetl) begin
      pc_write    = 1'b0;
      pc_sel      = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_write  = 1'b0;
      idex_flush  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      trap        = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + ((!pc_write && (state_q != ST_TRAP)) ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (ifid_flush ? 32'd1 : 32'd0);
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
